button_gesture_decoder: RTL

- Consumes the debounced level from the pull-up/debouncer button stage.
- Classifies each press as short, long or double, and emits one single-cycle pulse per gesture.
- Sits directly downstream of the debounced button and feeds control logic such as mode switches and menu stepping.
- Requires a clean, synchronous, glitch-free input; it does no debouncing of its own.

---
 rtl/button_pkg.sv | 27 ++
 rtl/button_gesture_decoder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the button gesture decoder.
//   state_t  : FSM state encoding (3 bits)
//   clog2_u  : bit count needed to hold a value, used for counter width checks
package button_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS1   = 3'd1,
    S_WAIT_GAP = 3'd2,
    S_PRESS2   = 3'd3,
    S_HELD     = 3'd4
  } state_t;

  // Number of bits needed to represent v (v=0 -> 0 bits, v=1 -> 1 bit).
  function automatic int unsigned clog2_u(input longint unsigned v);
    int unsigned n;
    longint unsigned x;
    n = 0;
    x = v;
    while (x != 0) begin
      n = n + 1;
      x = x >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/button_gesture_decoder.sv
// Classifies debounced button presses as short, long or double and emits
// one single-cycle pulse per gesture.
//   clk          : system clock
//   rst          : asynchronous, active-high reset
//   in           : debounced button level, synchronous to clk
//   pressed      : registered, polarity-normalised level (1 = pressed)
//   short_press  : pulse, single short press completed
//   long_press   : pulse, press reached LONG_CYCLES
//   double_press : pulse, second press of a double press
module button_gesture_decoder #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned LONG_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned CNT_WIDTH   = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  import button_pkg::*;

  localparam int unsigned MAX_CYCLES =
    (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;

  if (clog2_u(longint'(MAX_CYCLES)) > CNT_WIDTH) begin : g_bad_cnt_width
    $error("CNT_WIDTH too small for max(LONG_CYCLES, GAP_CYCLES)");
  end
  if (LONG_CYCLES < 2 || GAP_CYCLES < 2) begin : g_bad_limits
    $error("LONG_CYCLES and GAP_CYCLES must be >= 2");
  end

  localparam logic [CNT_WIDTH-1:0] LONG_LIM = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LIM  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = cnt;
    if (cnt != '1) begin
      cnt_inc = cnt + CNT_ONE;
    end
  end

  // Release/press checks are tested before the limit checks so a level
  // change on the limit edge wins over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pressed      <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      pressed      <= in ^ ACTIVE_LOW;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pressed) begin
            state <= S_PRESS1;
            cnt   <= CNT_ONE;
          end
        end
        S_PRESS1: begin
          if (!pressed) begin
            state <= S_WAIT_GAP;
            cnt   <= CNT_ONE;
          end else if (cnt == LONG_LIM) begin
            long_press <= 1'b1;
            state      <= S_HELD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_WAIT_GAP: begin
          if (pressed) begin
            state <= S_PRESS2;
            cnt   <= CNT_ONE;
          end else if (cnt == GAP_LIM) begin
            short_press <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_PRESS2: begin
          if (!pressed) begin
            double_press <= 1'b1;
            state        <= S_IDLE;
          end else if (cnt == LONG_LIM) begin
            // A long second press still reports as a double press only.
            double_press <= 1'b1;
            state        <= S_HELD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_HELD: begin
          if (!pressed) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
